// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// CLA_PIPE_OVF_EN adds the registered signed-overflow flag out_ovf.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef CLA_PIPE_OVF_EN
    logic             out_ovf;
`endif

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
`ifdef CLA_PIPE_OVF_EN
        , input out_ovf
`endif
    );

    // Adder side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
`ifdef CLA_PIPE_OVF_EN
        , output out_ovf
`endif
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices of 4-bit CLA groups with a
// registered carry between slices and valid/ready backpressure. Option: CLA_PIPE_OVF_EN.
module cla_pipe_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NG = SW / 4;

    // Returns the carry into every bit of a slice plus the slice carry-out in bit SW.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                              input logic cin);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [NG-1:0] gg;
        logic [NG-1:0] gp;
        logic [NG:0]   gc;
        logic [SW:0]   c;
        logic          acc;
        logic          pp;
        g = a & b;
        p = a ^ b;
        for (int gi = 0; gi < NG; gi++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = 3; j >= 0; j--) begin
                acc = acc | (pp & g[4*gi+j]);
                pp  = pp & p[4*gi+j];
            end
            gg[gi] = acc;
            gp[gi] = pp;
        end
        // Second level: each group carry is a flat sum-of-products over lower groups.
        gc[0] = cin;
        for (int gi = 0; gi < NG; gi++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = gi; j >= 0; j--) begin
                acc = acc | (pp & gg[j]);
                pp  = pp & gp[j];
            end
            gc[gi+1] = acc | (pp & cin);
        end
        for (int gi = 0; gi < NG; gi++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 1'b0;
                pp  = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    acc = acc | (pp & g[4*gi+j]);
                    pp  = pp & p[4*gi+j];
                end
                c[4*gi+i] = acc | (pp & gc[gi]);
            end
        end
        c[SW] = gc[NG];
        return c;
    endfunction

    logic [WIDTH-1:0]  b_cond;
    logic              c0;
    logic [STAGES-1:0] valid;
    logic [STAGES:0]   rdy;

    // Subtract is A + ~B + 1; carry-in is forced and in_cin ignored.
    assign b_cond = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign c0     = bus.in_sub | bus.in_cin;

    always_comb begin
        rdy         = '0;
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = ~valid[k] | rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LoW = (k + 1) * SW;     // completed sum bits after this stage
        localparam int unsigned InW = WIDTH - k * SW;   // unprocessed operand bits entering

        logic [InW-1:0] src_a;
        logic [InW-1:0] src_b;
        logic           src_c;
        logic           src_v;
        logic [SW:0]    cy;
        logic [SW-1:0]  slice_sum;
        logic [LoW-1:0] sum_d;
        logic [LoW-1:0] sum_q;
        logic           carry_q;
        logic           valid_q;

        if (k == 0) begin : g_src
            assign src_a = bus.in_a;
            assign src_b = b_cond;
            assign src_c = c0;
            assign src_v = bus.in_valid;
            assign sum_d = slice_sum;
        end else begin : g_src
            assign src_a = g_stage[k-1].g_hi.a_q;
            assign src_b = g_stage[k-1].g_hi.b_q;
            assign src_c = g_stage[k-1].carry_q;
            assign src_v = g_stage[k-1].valid_q;
            assign sum_d = {slice_sum, g_stage[k-1].sum_q};
        end

        assign cy        = cla_slice(src_a[SW-1:0], src_b[SW-1:0], src_c);
        assign slice_sum = src_a[SW-1:0] ^ src_b[SW-1:0] ^ cy[SW-1:0];
        assign valid[k]  = valid_q;

        // A stage only loads when downstream can take its current contents.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (rdy[k]) begin
                valid_q <= src_v;
                if (src_v) begin
                    carry_q <= cy[SW];
                    sum_q   <= sum_d;
                end
            end
        end

        if (InW > SW) begin : g_hi
            logic [InW-SW-1:0] a_q;
            logic [InW-SW-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (rdy[k] && src_v) begin
                    a_q <= src_a[InW-1:SW];
                    b_q <= src_b[InW-1:SW];
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = g_stage[STAGES-1].valid_q;
    assign bus.out_sum   = g_stage[STAGES-1].sum_q;
    assign bus.out_cout  = g_stage[STAGES-1].carry_q;

`ifdef CLA_PIPE_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (rdy[STAGES-1] && g_stage[STAGES-1].src_v) begin
            ovf_q <= g_stage[STAGES-1].cy[SW] ^ g_stage[STAGES-1].cy[SW-1];
        end
    end

    assign bus.out_ovf = ovf_q;
`endif
endmodule
